// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and limits for the bit-serial adder
package serial_adder_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit combinational add cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell LSB-first over WIDTH-bit operands
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry, fa_sum, fa_cout, last, accept, run;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign last      = cnt == CW'(WIDTH - 1);
  assign accept    = in_ready & in_valid & ~abort;
  assign run       = (state == RUN) & ~abort;
  fulladder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= abort            ? IDLE :
                  (state == IDLE) ? (in_valid ? RUN : IDLE) :
                  (state == RUN)  ? (last ? DONE : RUN) :
                  (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // Abort freezes the datapath so sum/cout keep whatever they last held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (run) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum   <= (sum >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last) cout <= fa_cout;
    end
  end
endmodule
